// File: rtl/mem_arb.sv
// Two-port memory arbiter: instruction fetch and load/store share one memory port.
// Data wins contention until fetch has lost STARVE_LIMIT times in a row.
module mem_arb #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] rsp_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  // state | meaning
  // IDLE  | nothing outstanding, arbitrate every cycle
  // REQ   | mem_req high, waiting for mem_gnt
  // WAIT  | accepted, waiting for mem_rvalid (re-arbitrates on it)
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic        owner_q, owner_d;  // 1 = data owns the outstanding transaction
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;

  logic arb_en, win_d, win_i, rsp_valid;

  always_comb begin
    arb_en = !reset && ((state_q == S_IDLE) || ((state_q == S_WAIT) && mem_rvalid));
    win_d  = arb_en && d_req && !(i_req && (starve_q == LIMIT));
    win_i  = arb_en && i_req && !win_d;

    state_d     = state_q;
    starve_d    = starve_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;

    case (state_q)
      S_IDLE: if (win_d || win_i) state_d = S_REQ;
      S_REQ: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: if (mem_rvalid) state_d = (win_d || win_i) ? S_REQ : S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (win_d) begin
      mem_req_d   = 1'b1;
      mem_we_d    = d_we;
      mem_addr_d  = d_addr;
      mem_wdata_d = d_wdata;
      mem_wstrb_d = d_we ? d_wstrb : 4'b0000;
      owner_d     = 1'b1;
      if (i_req) starve_d = starve_q + 4'd1;
    end else if (win_i) begin
      mem_req_d   = 1'b1;
      mem_we_d    = 1'b0;
      mem_addr_d  = i_addr;
      mem_wdata_d = 32'h0;
      mem_wstrb_d = 4'b0000;
      owner_d     = 1'b0;
      starve_d    = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      starve_q    <= 4'd0;
      owner_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_wstrb_q <= 4'b0000;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

  // Responses outside WAIT belong to no live transaction and are dropped.
  assign rsp_valid = !reset && (state_q == S_WAIT) && mem_rvalid;
  assign i_rvalid  = rsp_valid && !owner_q;
  assign d_rvalid  = rsp_valid && owner_q;
  assign rsp_rdata = rsp_valid ? mem_rdata : 32'h0;
  assign i_gnt     = win_i;
  assign d_gnt     = win_d;

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

endmodule
